// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the MIPS core back end.
package pipeline_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  // Source of the value written back to the register file.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  // Link outranks memory, memory outranks ALU.
  function automatic wb_sel_e wb_select(input logic link, input logic memtoreg);
    if (link)          return WB_LINK;
    else if (memtoreg) return WB_MEM;
    else               return WB_ALU;
  endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Write-through bypass for one ID-stage register read port.
module wb_bypass_mux
  import pipeline_pkg::*;
#(
  parameter int unsigned N      = DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [N-1:0]      wb_data,
  input  logic [ADDR_W-1:0] rd_reg,
  input  logic [N-1:0]      rf_data,
  output logic [N-1:0]      rd_data
);

  // Forward the retiring write when it targets the register being read.
  always_comb begin
    rd_data = rf_data;
    if (wb_en && (wb_reg == rd_reg)) rd_data = wb_data;
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, register-file write control, read bypass and
// retired-instruction counter.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned N      = DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_RegWrite,
  input  logic              in_MemtoReg,
  input  logic              in_Link,
  input  logic [ADDR_W-1:0] in_WriteRegister,
  input  logic [N-1:0]      in_ALUResult,
  input  logic [N-1:0]      in_MemReadData,
  input  logic [N-1:0]      in_PCPlus4,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [N-1:0]      ReadData1_rf,
  input  logic [N-1:0]      ReadData2_rf,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [N-1:0]      WriteData,
  output logic [N-1:0]      ReadData1,
  output logic [N-1:0]      ReadData2,
  output logic [CNT_W-1:0]  RetiredCount
);

  wb_sel_e           sel;
  logic [N-1:0]      cap_data;
  logic [ADDR_W-1:0] cap_reg;
  logic              cap_wflag;

  logic              valid_q, valid_d;
  logic              wflag_q, wflag_d;
  logic [ADDR_W-1:0] wreg_q,  wreg_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Select the write-back value, destination and write flag from MEM.
  always_comb begin
    sel = wb_select(in_Link, in_MemtoReg);
    unique case (sel)
      WB_LINK: cap_data = in_PCPlus4;
      WB_MEM:  cap_data = in_MemReadData;
      default: cap_data = in_ALUResult;
    endcase
    cap_reg   = in_Link ? ADDR_W'(REG_RA) : in_WriteRegister;
    cap_wflag = in_RegWrite | in_Link;
  end

  // Next WB state: flush beats stall, stall beats load.
  always_comb begin
    valid_d = valid_q;
    wflag_d = wflag_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    count_d = count_q;
    if (flush) begin
      valid_d = 1'b0;
      wflag_d = 1'b0;
      wreg_d  = '0;
      wdata_d = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      wflag_d = cap_wflag;
      wreg_d  = cap_reg;
      wdata_d = cap_data;
      if (in_valid) count_d = count_q + CNT_W'(1);
    end
  end

  // WB register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      wflag_q <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      wflag_q <= wflag_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  // Register-file write port; index 0 is never written.
  always_comb begin
    RegWrite      = valid_q & wflag_q & (wreg_q != ADDR_W'(REG_ZERO));
    WriteRegister = wreg_q;
    WriteData     = wdata_q;
    RetiredCount  = count_q;
  end

  wb_bypass_mux #(.N(N), .ADDR_W(ADDR_W)) u_bypass1 (
    .wb_en   (RegWrite),
    .wb_reg  (wreg_q),
    .wb_data (wdata_q),
    .rd_reg  (ReadRegister1),
    .rf_data (ReadData1_rf),
    .rd_data (ReadData1)
  );

  wb_bypass_mux #(.N(N), .ADDR_W(ADDR_W)) u_bypass2 (
    .wb_en   (RegWrite),
    .wb_reg  (wreg_q),
    .wb_data (wdata_q),
    .rd_reg  (ReadRegister2),
    .rf_data (ReadData2_rf),
    .rd_data (ReadData2)
  );

endmodule
